rob_mw: RTL and testbench
=========================

Name: rob_mw

Overview:
Parametrised multi-issue reorder buffer, successor to the single-wide ROB. Accepts up to DISP_W in-order dispatches per cycle and records up to CMP_W out-of-order completions per cycle. Retires up to RET_W consecutive completed entries from the head, in order. Supports branch-mispredict rollback, which discards all entries younger than a given ROB index. Sits between ID (dispatch), IC (complete) and IR (retire / freelist release).

Parameters:
ROB_SZ, 32, entry count; power of 2, at least 4
DISP_W, 2, dispatch slots per cycle
CMP_W, 2, completion ports per cycle
RET_W, 2, retire slots per cycle
TAG_W, 6, physical tag width; a tag is {valid, preg[TAG_W-1:0]}, so TAG_W+1 bits

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset: state clears on the rising clock edge while reset==0
disp_cnt  in  $clog2(DISP_W+1)  number of dispatch requests this cycle, slots 0..disp_cnt-1
disp_t  in  DISP_W*(TAG_W+1)  new destination tag per slot
disp_t_old  in  DISP_W*(TAG_W+1)  previous mapping per slot
disp_ok  out  1  combinational; 1 when free_cnt >= disp_cnt
disp_idx  out  DISP_W*$clog2(ROB_SZ)  ROB index allocated to each slot (tail+k)
free_cnt  out  $clog2(ROB_SZ)+1  registered; ROB_SZ minus occupancy
cmp_en  in  CMP_W  completion valid per port
cmp_idx  in  CMP_W*$clog2(ROB_SZ)  ROB index completed per port
ret_valid  out  RET_W  prefix mask of retiring slots
ret_t  out  RET_W*(TAG_W+1)  retiring tag per slot
ret_t_old  out  RET_W*(TAG_W+1)  tag to free per slot
sq_en  in  1  rollback request
sq_idx  in  $clog2(ROB_SZ)  index of the branch; that entry stays, all younger entries are discarded
empty  out  1  registered; occupancy==0

Behaviour:
- State: entries {valid, complete, t, t_old}; head and tail pointers of $clog2(ROB_SZ)+1 bits (wrap bit plus index); occupancy count.
- Reset (reset==0 at an edge): head=tail=0, count=0, all valid=0 and complete=0, free_cnt=ROB_SZ, empty=1, ret_valid=0. A reset asserted mid-operation discards every entry; no retire occurs in that cycle.
- Dispatch: accepted all-or-nothing when disp_ok && disp_cnt!=0 && !sq_en.
  - Slot k writes the entry at tail+k with valid=1, complete=0.
  - tail advances by disp_cnt.
  - Dispatched entries become visible to retire/complete the next cycle.
- free_cnt reflects the state at the start of the cycle. Slots freed by a retire in the same cycle cannot be reused until the next cycle.
- Complete: for each cmp_en[p], set complete=1 on entry cmp_idx[p] if it is valid.
  - Completion to an invalid entry is ignored.
  - Duplicate indices across ports are harmless.
- Retire (combinational from registered state): ret_valid[k]=1 iff entries head..head+k are all valid && complete, with k < RET_W.
  - ret_valid is always a prefix (e.g. 2'b01, never 2'b10).
  - On the clock edge: retired entries have valid=0, head advances by popcount(ret_valid).
- Completions presented in cycle N are retireable in cycle N+1, not in the same cycle (no bypass).
- Rollback (sq_en=1):
  - Invalidate every entry strictly younger than sq_idx, up to tail-1.
  - tail <= sq_idx+1 (with the wrap bit derived from head/count).
  - Dispatch is suppressed that cycle.
  - Same-cycle retire of older entries still happens. sq_idx must be valid and not retiring in that cycle (protocol requirement, checked by assertion).
  - Same-cycle completions to discarded entries are dropped.
- Count update: count <= count + accepted_disp - retired - squashed. Widths are $clog2(ROB_SZ)+1; the value never exceeds ROB_SZ.
- Wrap-around: all index arithmetic is mod ROB_SZ; full vs empty is distinguished by the pointer wrap bit.
- Full: free_cnt=0, so disp_ok=0 for any disp_cnt>0. disp_ok=1 when disp_cnt=0.

Optional Feature:
ROB_PERF_CNT_EN
- Defined:
  - Adds outputs perf_retired (32b), perf_full_cyc (32b) and perf_squashed (32b), zeroed at reset.
  - perf_retired increments by popcount(ret_valid) each cycle.
  - perf_full_cyc increments on each cycle with free_cnt=0 and disp_cnt>0.
  - perf_squashed increments by the number of entries discarded.
  - All counters saturate at all-ones.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - TAG struct {valid, preg}
  - ROB_ENTRY struct
  - ROB_IDX typedef
  - Default parameter constants
- Sub-module rob_retire_sel: combinational prefix-select of up to RET_W ready entries from head.

Test Plan:
1. Reset held low 2 cycles, then high -> free_cnt=32, empty=1, ret_valid=0.
2. Dispatch 2/cycle for 16 cycles -> free_cnt=0, disp_ok=0 for disp_cnt=1; a 17th request is not accepted; tail wraps to 0.
3. Complete idx 1 then idx 0 -> ret_valid=2'b00 until idx 0 is complete; the following cycle ret_valid=2'b11 with the tags of entries 0 and 1.
4. Entries 0..5 valid, entry 0 complete, sq_en=1 with sq_idx=2 in the same cycle as cmp_idx=4 -> entry 0 retires; entries 3..5 are discarded; free_cnt rises by 4 the next cycle; completion of 4 is dropped.
5. Full ROB; same cycle retire 2 and disp_cnt=2 -> dispatch is rejected; next cycle free_cnt=2 and dispatch is accepted.
6. reset driven low while 10 entries are in flight -> next cycle empty=1, free_cnt=32, no ret_valid.

Source files
------------

// File: rtl/rob_mw_pkg.sv
// Shared types, default parameters and helpers for the multi-issue reorder buffer.
package rob_mw_pkg;

  localparam int ROB_SZ_DEF = 32;
  localparam int DISP_W_DEF = 2;
  localparam int CMP_W_DEF  = 2;
  localparam int RET_W_DEF  = 2;
  localparam int TAG_W_DEF  = 6;

  typedef logic [$clog2(ROB_SZ_DEF)-1:0] rob_idx_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] preg;
  } tag_t;

  typedef struct packed {
    logic valid;
    logic complete;
    tag_t t;
    tag_t t_old;
  } rob_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/rob_mw_retire_sel.sv
// Combinational prefix select of up to RET_W ready entries starting at the ROB head.
module rob_retire_sel
  import rob_mw_pkg::*;
#(
  parameter int RET_W = RET_W_DEF
) (
  input  logic [RET_W-1:0]           i_ready,
  output logic [RET_W-1:0]           o_sel,
  output logic [$clog2(RET_W+1)-1:0] o_cnt
);

  localparam int CW = $clog2(RET_W + 1);

  logic w_run;

  // The first entry that is not ready closes the window for all younger slots.
  always_comb begin
    w_run = 1'b1;
    o_sel = '0;
    o_cnt = '0;
    for (int unsigned k = 0; k < RET_W; k++) begin
      w_run    = w_run & i_ready[k];
      o_sel[k] = w_run;
      o_cnt    = o_cnt + CW'(w_run);
    end
  end

endmodule

// File: rtl/rob_mw.sv
// Multi-issue reorder buffer: in-order dispatch, out-of-order completion, in-order retire, rollback.
// Optional performance counters are enabled with `define ROB_PERF_CNT_EN.
module rob_mw
  import rob_mw_pkg::*;
#(
  parameter int ROB_SZ = ROB_SZ_DEF,
  parameter int DISP_W = DISP_W_DEF,
  parameter int CMP_W  = CMP_W_DEF,
  parameter int RET_W  = RET_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [$clog2(DISP_W+1)-1:0]      disp_cnt,
  input  logic [DISP_W*(TAG_W+1)-1:0]      disp_t,
  input  logic [DISP_W*(TAG_W+1)-1:0]      disp_t_old,
  output logic                             disp_ok,
  output logic [DISP_W*$clog2(ROB_SZ)-1:0] disp_idx,
  output logic [$clog2(ROB_SZ):0]          free_cnt,
  input  logic [CMP_W-1:0]                 cmp_en,
  input  logic [CMP_W*$clog2(ROB_SZ)-1:0]  cmp_idx,
  output logic [RET_W-1:0]                 ret_valid,
  output logic [RET_W*(TAG_W+1)-1:0]       ret_t,
  output logic [RET_W*(TAG_W+1)-1:0]       ret_t_old,
  input  logic                             sq_en,
  input  logic [$clog2(ROB_SZ)-1:0]        sq_idx,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]                      perf_retired,
  output logic [31:0]                      perf_full_cyc,
  output logic [31:0]                      perf_squashed,
`endif
  output logic                             empty
);

  localparam int IW  = $clog2(ROB_SZ);
  localparam int PW  = IW + 1;
  localparam int TW  = TAG_W + 1;
  localparam int RCW = $clog2(RET_W + 1);

  typedef struct packed {
    logic          valid;
    logic          complete;
    logic [TW-1:0] t;
    logic [TW-1:0] t_old;
  } ent_t;

  ent_t          r_ent [ROB_SZ];
  logic [PW-1:0] r_head, r_tail, r_count, r_free_cnt;
  logic          r_empty;

  logic [IW-1:0]     w_head_idx, w_tail_idx, w_sq_off, w_off, w_ridx;
  logic [RET_W-1:0]  w_ready, w_sel, w_ret;
  logic [RCW-1:0]    w_sel_n;
  logic [PW-1:0]     w_ret_n, w_disp_n, w_keep, w_squashed, w_count_nxt;
  logic [ROB_SZ-1:0] w_sq_kill;
  logic              w_disp_acc, w_sq_legal;

  assign w_head_idx = r_head[IW-1:0];
  assign w_tail_idx = r_tail[IW-1:0];

  always_comb begin
    w_ready   = '0;
    ret_t     = '0;
    ret_t_old = '0;
    w_ridx    = '0;
    for (int unsigned k = 0; k < RET_W; k++) begin
      w_ridx     = IW'(w_head_idx + IW'(k));
      w_ready[k] = r_ent[w_ridx].valid && r_ent[w_ridx].complete;
      ret_t[k*TW +: TW]     = r_ent[w_ridx].t;
      ret_t_old[k*TW +: TW] = r_ent[w_ridx].t_old;
    end
  end

  rob_retire_sel #(.RET_W(RET_W)) u_sel (
    .i_ready (w_ready),
    .o_sel   (w_sel),
    .o_cnt   (w_sel_n)
  );

  // Nothing retires while reset is held, so the retire view is masked too.
  assign w_ret     = reset ? w_sel : '0;
  assign w_ret_n   = reset ? PW'(w_sel_n) : '0;
  assign ret_valid = w_ret;

  assign disp_ok    = r_free_cnt >= PW'(disp_cnt);
  assign w_disp_acc = disp_ok && (disp_cnt != '0) && !sq_en;
  assign w_disp_n   = w_disp_acc ? PW'(disp_cnt) : '0;

  always_comb begin
    disp_idx = '0;
    for (int unsigned k = 0; k < DISP_W; k++)
      disp_idx[k*IW +: IW] = IW'(w_tail_idx + IW'(k));
  end

  // Entries kept by a rollback are head..sq_idx inclusive; the rest of the live range is discarded.
  assign w_sq_off   = sq_idx - w_head_idx;
  assign w_keep     = PW'(w_sq_off) + PW'(1);
  assign w_squashed = sq_en ? (r_count - w_keep) : '0;
  assign w_sq_legal = r_ent[sq_idx].valid && (PW'(w_sq_off) >= w_ret_n);

  always_comb begin
    w_sq_kill = '0;
    w_off     = '0;
    for (int unsigned i = 0; i < ROB_SZ; i++) begin
      w_off        = IW'(IW'(i) - w_head_idx);
      w_sq_kill[i] = sq_en && (PW'(w_off) >= w_keep) && (PW'(w_off) < r_count);
    end
  end

  assign w_count_nxt = r_count + w_disp_n - w_ret_n - w_squashed;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ROB_SZ; i++) r_ent[i] <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_free_cnt <= PW'(ROB_SZ);
      r_empty    <= 1'b1;
    end else begin
      for (int unsigned p = 0; p < CMP_W; p++)
        if (cmp_en[p] && r_ent[cmp_idx[p*IW +: IW]].valid)
          r_ent[cmp_idx[p*IW +: IW]].complete <= 1'b1;
      for (int unsigned k = 0; k < RET_W; k++)
        if (w_ret[k]) begin
          r_ent[IW'(w_head_idx + IW'(k))].valid    <= 1'b0;
          r_ent[IW'(w_head_idx + IW'(k))].complete <= 1'b0;
        end
      if (sq_en) begin
        for (int unsigned i = 0; i < ROB_SZ; i++)
          if (w_sq_kill[i]) begin
            r_ent[i].valid    <= 1'b0;
            r_ent[i].complete <= 1'b0;
          end
        r_tail <= r_head + w_keep;
      end else if (w_disp_acc) begin
        for (int unsigned k = 0; k < DISP_W; k++)
          if (k < 32'(disp_cnt))
            r_ent[IW'(w_tail_idx + IW'(k))] <= '{valid: 1'b1, complete: 1'b0,
                                                t: disp_t[k*TW +: TW],
                                                t_old: disp_t_old[k*TW +: TW]};
        r_tail <= r_tail + w_disp_n;
      end
      r_head     <= r_head + w_ret_n;
      r_count    <= w_count_nxt;
      r_free_cnt <= PW'(ROB_SZ) - w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
    end
  end

  assign free_cnt = r_free_cnt;
  assign empty    = r_empty;

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_retired  <= '0;
      perf_full_cyc <= '0;
      perf_squashed <= '0;
    end else begin
      perf_retired  <= sat_add32(perf_retired, 32'(w_ret_n));
      perf_squashed <= sat_add32(perf_squashed, 32'(w_squashed));
      if (r_free_cnt == '0 && disp_cnt != '0)
        perf_full_cyc <= sat_add32(perf_full_cyc, 32'd1);
    end
  end
`endif

  assert property (@(posedge clock) disable iff (!reset) sq_en |-> w_sq_legal);
  assert property (@(posedge clock) disable iff (!reset) r_tail == r_head + r_count);

endmodule

// File: tb/tb_rob_mw.sv
// Bench for rob_mw: a hand-computed vector table for the corner cases plus a queue model of in-flight entries.
module tb_rob_mw;
  import rob_mw_pkg::*;

  localparam int SZ = 32;
  localparam int DW = 2;
  localparam int CW = 2;
  localparam int RW = 2;
  localparam int TW = 7;
  localparam int IW = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      disp_cnt;
  logic [DW*TW-1:0] disp_t, disp_t_old;
  logic            disp_ok;
  logic [DW*IW-1:0] disp_idx;
  logic [IW:0]     free_cnt;
  logic [CW-1:0]   cmp_en;
  logic [CW*IW-1:0] cmp_idx;
  logic [RW-1:0]   ret_valid;
  logic [RW*TW-1:0] ret_t, ret_t_old;
  logic            sq_en;
  logic [IW-1:0]   sq_idx;
  logic            empty;

  rob_mw #(.ROB_SZ(SZ), .DISP_W(DW), .CMP_W(CW), .RET_W(RW), .TAG_W(6)) dut (
    .clock(clock), .reset(reset), .disp_cnt(disp_cnt), .disp_t(disp_t), .disp_t_old(disp_t_old),
    .disp_ok(disp_ok), .disp_idx(disp_idx), .free_cnt(free_cnt), .cmp_en(cmp_en), .cmp_idx(cmp_idx),
    .ret_valid(ret_valid), .ret_t(ret_t), .ret_t_old(ret_t_old), .sq_en(sq_en), .sq_idx(sq_idx),
    .empty(empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TW-1:0] t;
    logic [TW-1:0] t_old;
    int            idx;
    bit            done;
  } rec_t;

  typedef struct {
    bit       chk;
    bit       rst;
    int       dcnt;
    bit [1:0] cen;
    int       ci0;
    int       ci1;
    bit       sq;
    int       sqi;
    int       efree;
    int       eret;
    bit       eok;
  } vec_t;

  rec_t q[$];
  vec_t tv[$];
  int   nvec = 0;
  int   nfail = 0;
  int   seq = 0;
  int   m_tail = 0;
  bit   m_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_tag(input int s, input bit old);
    tag_t        tg;
    logic [31:0] v;
    v       = s;
    tg.valid = 1'b1;
    tg.preg  = old ? ~v[5:0] : v[5:0];
    return tg;
  endfunction

  function automatic int exp_ret_n();
    int n = 0;
    for (int k = 0; k < RW; k++) begin
      if (k >= q.size()) break;
      if (!q[k].done) break;
      n++;
    end
    return n;
  endfunction

  function automatic vec_t mkv(input bit c, input bit r, input int d, input bit [1:0] ce,
                               input int c0, input int c1, input bit s, input int si,
                               input int ef, input int er, input bit eo);
    vec_t v;
    v.chk = c; v.rst = r; v.dcnt = d; v.cen = ce; v.ci0 = c0; v.ci1 = c1;
    v.sq = s; v.sqi = si; v.efree = ef; v.eret = er; v.eok = eo;
    return v;
  endfunction

  task automatic row(input bit c, input bit r, input int d, input bit [1:0] ce, input int c0,
                     input int c1, input bit s, input int si, input int ef, input int er, input bit eo);
    tv.push_back(mkv(c, r, d, ce, c0, c1, s, si, ef, er, eo));
  endtask

  task automatic step(input vec_t v);
    int          n, efree, ci;
    bit          eok, acc;
    logic [RW-1:0] em;
    rec_t        rc;
    reset    = v.rst ? 1'b0 : 1'b1;
    disp_cnt = 2'(v.dcnt);
    for (int k = 0; k < DW; k++) begin
      disp_t[k*TW +: TW]     = mk_tag(seq + k, 1'b0);
      disp_t_old[k*TW +: TW] = mk_tag(seq + k, 1'b1);
    end
    cmp_en  = v.cen;
    cmp_idx = {5'(v.ci1), 5'(v.ci0)};
    sq_en   = v.sq;
    sq_idx  = 5'(v.sqi);
    @(negedge clock);
    n     = v.rst ? 0 : exp_ret_n();
    efree = SZ - q.size();
    eok   = efree >= v.dcnt;
    if (m_known) begin
      em = '0;
      for (int k = 0; k < n; k++) em[k] = 1'b1;
      chk("ret_valid", 32'(ret_valid), 32'(em));
      for (int k = 0; k < n; k++) begin
        chk("ret_t", 32'(ret_t[k*TW +: TW]), 32'(q[k].t));
        chk("ret_t_old", 32'(ret_t_old[k*TW +: TW]), 32'(q[k].t_old));
      end
      chk("free_cnt", 32'(free_cnt), efree);
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("disp_ok", 32'(disp_ok), 32'(eok));
      for (int k = 0; k < v.dcnt; k++)
        chk("disp_idx", 32'(disp_idx[k*IW +: IW]), (m_tail + k) % SZ);
    end
    if (v.chk) begin
      chk("tbl_free_cnt", 32'(free_cnt), v.efree);
      chk("tbl_ret_valid", 32'(ret_valid), v.eret);
      chk("tbl_disp_ok", 32'(disp_ok), 32'(v.eok));
    end
    if (v.rst) begin
      q.delete();
      m_tail  = 0;
      m_known = 1'b1;
    end else begin
      acc = eok && (v.dcnt != 0) && !v.sq;
      for (int k = 0; k < n; k++) void'(q.pop_front());
      if (v.sq) begin
        while (q.size() > 0 && q[q.size()-1].idx != v.sqi) void'(q.pop_back());
        m_tail = (v.sqi + 1) % SZ;
      end
      for (int p = 0; p < CW; p++) begin
        ci = (p == 0) ? v.ci0 : v.ci1;
        if (v.cen[p])
          foreach (q[j]) if (q[j].idx == ci) q[j].done = 1'b1;
      end
      if (acc) begin
        for (int k = 0; k < v.dcnt; k++) begin
          rc.t     = mk_tag(seq + k, 1'b0);
          rc.t_old = mk_tag(seq + k, 1'b1);
          rc.idx   = (m_tail + k) % SZ;
          rc.done  = 1'b0;
          q.push_back(rc);
        end
        m_tail = (m_tail + v.dcnt) % SZ;
        seq    = seq + v.dcnt;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset, then fill to full in 16 cycles; a further request is refused
    row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) row(1, 0, 2, 0, 0, 0, 0, 0, 32 - 2*i, 0, 1);
    row(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // complete 1 then 0; both retire together one cycle later
    row(1, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 1);
    row(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1);
    row(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    // refill, then retire 2 while full: same-cycle dispatch refused, accepted next cycle
    row(1, 0, 2, 0, 0, 0, 0, 0, 2, 0, 1);
    row(1, 0, 0, 2'b11, 2, 3, 0, 0, 0, 0, 1);
    row(1, 0, 2, 0, 0, 0, 0, 0, 0, 3, 0);
    row(1, 0, 2, 0, 0, 0, 0, 0, 2, 0, 1);
    // reset while full
    row(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // entries 0..5, 0 complete; rollback to 2 with a completion to 4 in the same cycle
    row(1, 0, 2, 0, 0, 0, 0, 0, 32, 0, 1);
    row(1, 0, 2, 0, 0, 0, 0, 0, 30, 0, 1);
    row(1, 0, 2, 2'b01, 0, 0, 0, 0, 28, 0, 1);
    row(1, 0, 0, 2'b01, 4, 0, 1, 2, 26, 1, 1);
    row(1, 0, 0, 2'b11, 1, 2, 0, 0, 30, 0, 1);
    row(1, 0, 0, 0, 0, 0, 0, 0, 30, 3, 1);
    // reuse slots 3 and 4: only 3 may retire, the dropped completion must not linger on 4
    row(1, 0, 2, 0, 0, 0, 0, 0, 32, 0, 1);
    row(1, 0, 0, 2'b01, 3, 0, 0, 0, 30, 0, 1);
    row(1, 0, 0, 0, 0, 0, 0, 0, 30, 1, 1);
    // build 10 in flight with a ready head, then reset
    row(1, 0, 2, 0, 0, 0, 0, 0, 31, 0, 1);
    row(1, 0, 2, 0, 0, 0, 0, 0, 29, 0, 1);
    row(1, 0, 2, 0, 0, 0, 0, 0, 27, 0, 1);
    row(1, 0, 2, 0, 0, 0, 0, 0, 25, 0, 1);
    row(1, 0, 1, 2'b11, 4, 5, 0, 0, 23, 0, 1);
    row(1, 1, 0, 0, 0, 0, 0, 0, 22, 0, 1);
    row(1, 0, 0, 0, 0, 0, 0, 0, 32, 0, 1);

    for (int i = 0; i < tv.size(); i++) step(tv[i]);

    for (int c = 0; c < 400; c++) begin
      vec_t v;
      int   n;
      v = mkv(0, 0, $urandom_range(0, 2), 2'($urandom_range(0, 3)), 0, 0, 0, 0, 0, 0, 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) v.ci0 = q[$urandom_range(0, q.size()-1)].idx;
      else v.ci0 = $urandom_range(0, SZ-1);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) v.ci1 = q[$urandom_range(0, q.size()-1)].idx;
      else v.ci1 = $urandom_range(0, SZ-1);
      n = exp_ret_n();
      if ($urandom_range(0, 15) == 0 && q.size() > n) begin
        v.sq  = 1'b1;
        v.sqi = q[$urandom_range(n, q.size()-1)].idx;
      end
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
